edge_timestamp: RTL and testbench

Timestamps edges on an asynchronous input against the 10 kHz phase counter (modulo-DIVFACTOR count at 125 MHz). It sits directly downstream of the divider and consumes its count bus as the fine phase. It extends that phase with a wrap (period) counter. Events are buffered in a small FIFO and presented on a valid/ready stream for the capture/readout logic.

---
 rtl/edge_timestamp_pkg.sv | 35 +++
 rtl/edge_timestamp_fifo.sv | 61 ++++++
 rtl/edge_timestamp.sv | 129 ++++++++++++
 tb/tb_edge_timestamp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_timestamp_pkg.sv
// ============================================================================
// edge_timestamp_pkg
// Shared constants, FIFO entry record and entry-width helper for edge_timestamp.
// Honours macro EDGE_TIMESTAMP_FALLING_EN (adds the edge bit to stored entries).
// Revision: 1.0
// ============================================================================
`default_nettype none

package edge_timestamp_pkg;

    localparam int C_DIVFACTOR = 12500;
    localparam int C_PHASE_W   = 14;
    localparam int C_PERIOD_W  = 16;
    localparam int C_DEPTH     = 4;

    typedef struct packed {
        logic [C_PHASE_W-1:0]  phase;
        logic [C_PERIOD_W-1:0] period;
        logic                  rising;
    } ts_entry_t;

    // Rising-only builds never need to store the edge direction.
    function automatic int entry_width(input int phase_w, input int period_w);
`ifdef EDGE_TIMESTAMP_FALLING_EN
        return phase_w + period_w + 1;
`else
        return phase_w + period_w;
`endif
    endfunction

    localparam int C_ENTRY_W = entry_width(C_PHASE_W, C_PERIOD_W);

endpackage

`default_nettype wire

// File: rtl/edge_timestamp_fifo.sv
// ============================================================================
// ts_fifo
// Parameterised synchronous show-ahead FIFO; head data is visible while !empty.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ts_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/edge_timestamp.sv
// ============================================================================
// edge_timestamp
// Timestamps sig_in edges with {phase, period} and queues them on a stream.
// Macro EDGE_TIMESTAMP_FALLING_EN: also queue falling edges (out_rising = 0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module edge_timestamp
    import edge_timestamp_pkg::*;
#(
    parameter int DIVFACTOR = C_DIVFACTOR,
    parameter int PHASE_W   = C_PHASE_W,
    parameter int PERIOD_W  = C_PERIOD_W,
    parameter int DEPTH     = C_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PHASE_W-1:0]  phase_in,
    input  logic                sig_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PHASE_W-1:0]  out_phase,
    output logic [PERIOD_W-1:0] out_period,
    output logic                out_rising,
    output logic                overflow,
    input  logic                clear_ovf
);

    localparam int                 ENTRY_W      = entry_width(PHASE_W, PERIOD_W);
    localparam logic [PHASE_W-1:0] C_PHASE_LAST = PHASE_W'(DIVFACTOR - 1);

    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [PERIOD_W-1:0] r_period;
    logic                r_overflow;

    logic                w_rise;
    logic                w_event;
    logic                w_wrap;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic [ENTRY_W-1:0]  w_wr_data;
    logic [ENTRY_W-1:0]  w_rd_data;
    logic [PHASE_W-1:0]  w_head_phase;
    logic [PERIOD_W-1:0] w_head_period;
    logic                w_head_rising;

    // s1/s2 resynchronise; s3 is the previous s2 for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;
    assign w_wrap = (phase_in == C_PHASE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_period <= '0;
        end else if (w_wrap) begin
            r_period <= r_period + PERIOD_W'(1);
        end
    end

`ifdef EDGE_TIMESTAMP_FALLING_EN
    logic w_fall;
    assign w_fall        = ~r_s2 & r_s3;
    assign w_event       = w_rise | w_fall;
    assign w_wr_data     = {phase_in, r_period, w_rise};
    assign w_head_phase  = w_rd_data[ENTRY_W-1 -: PHASE_W];
    assign w_head_period = w_rd_data[PERIOD_W:1];
    assign w_head_rising = w_rd_data[0];
`else
    assign w_event       = w_rise;
    assign w_wr_data     = {phase_in, r_period};
    assign w_head_phase  = w_rd_data[ENTRY_W-1 -: PHASE_W];
    assign w_head_period = w_rd_data[PERIOD_W-1:0];
    assign w_head_rising = 1'b1;
`endif

    assign w_pop  = out_valid & out_ready;
    assign w_drop = w_event & w_full & ~w_pop;

    ts_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_event),
        .i_pop   (w_pop),
        .i_data  (w_wr_data),
        .o_data  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A drop in the same cycle as clear_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // Stale RAM contents never leak out while the queue is empty.
    assign out_valid  = ~w_empty;
    assign out_phase  = out_valid ? w_head_phase  : '0;
    assign out_period = out_valid ? w_head_period : '0;
    assign out_rising = out_valid & w_head_rising;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_edge_timestamp.sv
// ============================================================================
// tb_edge_timestamp
// Self-checking bench: queue-level reference model plus directed literal checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_edge_timestamp;

    localparam int DIV = 12500;
    localparam int DEP = 4;
`ifdef EDGE_TIMESTAMP_FALLING_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] phase_in;
    logic        sig_in;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_phase;
    logic [15:0] out_period;
    logic        out_rising;
    logic        overflow;
    logic        clear_ovf;

    always #4 clk = ~clk;

    edge_timestamp dut (
        .clk        (clk),
        .reset      (reset),
        .phase_in   (phase_in),
        .sig_in     (sig_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_phase  (out_phase),
        .out_period (out_period),
        .out_rising (out_rising),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    typedef struct {
        int phase;
        int period;
        bit rising;
    } ent_t;

    ent_t mq[$];
    bit   sh1, sh2, sh3;
    bit   movf;
    int   mper;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sig sampled 2 edges back vs 3 edges back decides an edge event.
    task automatic step();
        bit   rise, fall, ev, pop, accept;
        int   sz;
        ent_t e;
        if (reset) begin
            mq.delete();
            movf = 1'b0;
            mper = 0;
            sh1 = 1'b0; sh2 = 1'b0; sh3 = 1'b0;
        end else begin
            rise   = sh2 & ~sh3;
            fall   = ~sh2 & sh3;
            ev     = rise | (FALL_EN & fall);
            sz     = mq.size();
            pop    = (sz > 0) && out_ready;
            accept = (sz < DEP) || pop;
            if (pop) void'(mq.pop_front());
            if (ev && accept) begin
                e.phase = int'(phase_in); e.period = mper; e.rising = rise;
                mq.push_back(e);
            end
            if (ev && !accept) movf = 1'b1;
            else if (clear_ovf) movf = 1'b0;
            if (int'(phase_in) == DIV - 1) mper = (mper + 1) % 65536;
            sh3 = sh2; sh2 = sh1; sh1 = sig_in;
        end
        @(posedge clk);
        #1;
        phase_in = 14'((int'(phase_in) + 1) % DIV);
        begin
            bit v;
            v = (mq.size() > 0);
            check("cycle{valid,phase,period,rising,ovf}",
                  {out_valid, out_phase, out_period, out_rising, overflow},
                  {v, v ? 14'(mq[0].phase) : 14'd0, v ? 16'(mq[0].period) : 16'd0,
                   v & (FALL_EN ? mq[0].rising : 1'b1), movf});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) step();
        out_ready = 1'b0;
    endtask

    initial begin
        int n, p0, hold;
        reset = 1'b1; sig_in = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0; phase_in = '0;
        repeat (3) step();
        reset = 1'b0;
        repeat (50) step();
        check("idle_valid",  out_valid,  0);
        check("idle_phase",  out_phase,  0);
        check("idle_period", out_period, 0);
        check("idle_rising", out_rising, 0);
        check("idle_ovf",    overflow,   0);

        // First edge: phase 100 before E0 -> captured at 102, valid after E2
        phase_in = 14'd100; sig_in = 1'b1;
        step(); step();
        check("lat_valid_E1", out_valid, 0);
        step();
        check("lat_valid_E2", out_valid, 1);
        check("lat_phase",    out_phase, 102);
        check("lat_period",   out_period, 0);
        check("lat_rising",   out_rising, 1);
        sig_in = 1'b0;
        drain(6);

        // Period wraps, then capture exactly at the last phase
        do_reset();
        repeat (3) begin phase_in = 14'(DIV - 1); step(); end
        phase_in = 14'(DIV - 3); sig_in = 1'b1;
        repeat (3) step();
        check("wrap_phase",  out_phase,  12499);
        check("wrap_period", out_period, 3);
        sig_in = 1'b0;
        drain(6);
        phase_in = 14'd3; sig_in = 1'b1;
        repeat (3) step();
        check("post_wrap_phase",  out_phase,  5);
        check("post_wrap_period", out_period, 4);
        sig_in = 1'b0;
        drain(6);

        // Overflow: 6 pulses with no reader
        do_reset();
        phase_in = '0;
        repeat (6) begin
            sig_in = 1'b1; step(); step();
            sig_in = 1'b0; step(); step();
        end
        repeat (4) step();
        check("ovf_set",        overflow,   1);
        check("ovf_head_phase", out_phase,  2);
        check("ovf_head_rise",  out_rising, 1);
        drain(1);
        check("ovf_second_phase", out_phase, FALL_EN ? 4 : 6);
        n = 0;
        out_ready = 1'b1;
        repeat (8) begin if (out_valid) n++; step(); end
        out_ready = 1'b0;
        check("ovf_remaining", n, 3);
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO with a pop coinciding with the incoming edge
        do_reset();
        phase_in = '0;
        while (mq.size() < DEP) begin sig_in = ~sig_in; repeat (4) step(); end
        if (!FALL_EN && sig_in) begin sig_in = 1'b0; repeat (4) step(); end
        sig_in = ~sig_in;
        step(); step();
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("full_pop_ovf", overflow, 0);
        n = 0;
        out_ready = 1'b1;
        repeat (8) begin if (out_valid) n++; step(); end
        out_ready = 1'b0;
        check("full_pop_occupancy", n, 4);
        sig_in = 1'b0; repeat (4) step(); drain(4);

        // 10-cycle pulse
        do_reset();
        phase_in = '0; sig_in = 1'b1;
        repeat (10) step();
        sig_in = 1'b0;
        repeat (6) step();
        check("pulse_first_rise",  out_rising, 1);
        check("pulse_first_phase", out_phase,  2);
        p0 = int'(out_phase);
        drain(1);
        check("pulse_second_valid", out_valid, FALL_EN);
`ifdef EDGE_TIMESTAMP_FALLING_EN
        check("pulse_second_rise",  out_rising, 0);
        check("pulse_phase_delta",  int'(out_phase) - p0, 10);
`endif
        drain(2);

        // Randomised traffic
        do_reset();
        hold = 1;
        for (int i = 0; i < 4000; i++) begin
            out_ready = ($urandom_range(0, 1) == 1);
            clear_ovf = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            if (--hold == 0) begin
                sig_in = ~sig_in;
                hold = $urandom_range(1, 6);
            end
            if ($urandom_range(0, 99) == 0) phase_in = 14'(DIV - $urandom_range(1, 3));
            step();
        end
        reset = 1'b0; clear_ovf = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
